// File: rtl/apb_timer_pkg.sv
// Shared register map, CTRL bit positions and the CTRL layout for the APB timer array.
// Pure declarations; no timing or flow control.
package apb_timer_pkg;

  localparam int LOAD_OFF        = 'h0;
  localparam int VALUE_OFF       = 'h4;
  localparam int CTRL_OFF        = 'h8;
  localparam int EOI_OFF         = 'hC;
  localparam int CH_STRIDE       = 'h10;

  localparam int INTSTAT_ADDR    = 'h100;
  localparam int EOI_ALL_ADDR    = 'h104;
  localparam int RAWINTSTAT_ADDR = 'h108;
  localparam int PRESCALE_ADDR   = 'h10C;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_MODE_BIT    = 1;
  localparam int CTRL_MASK_BIT    = 2;
  localparam int CTRL_ONESHOT_BIT = 3;

  localparam int PRESCALE_W = 16;

  typedef struct packed {
    logic oneshot;
    logic mask;
    logic mode;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/apb_timer_channel.sv
// One down-counter: enable-edge load, reload on terminal tick, one-shot stop, raw/masked interrupt.
// Counter and raw_int update on the edge after the tick; no backpressure.
module apb_timer_channel
  import apb_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             tick,
  input  ctrl_t            ctrl,
  input  logic [CNT_W-1:0] load_val,
  input  logic             eoi_clr,
  output logic [CNT_W-1:0] count,
  output logic             raw_int,
  output logic             timer_int,
  output logic             oneshot_clr
);

  logic             en_q;
  logic             terminal;
  logic [CNT_W-1:0] reload_val;

  assign reload_val  = ctrl.mode ? load_val : '1;
  // The enable-edge cycle only loads, so a terminal tick needs EN to have been high already.
  assign terminal    = ctrl.en && en_q && tick && (count == '0);
  assign oneshot_clr = terminal && ctrl.oneshot;
  assign timer_int   = raw_int && !ctrl.mask;

  always_ff @(posedge pclk) begin
    if (preset) begin
      en_q    <= 1'b0;
      count   <= '1;
      raw_int <= 1'b0;
    end else begin
      en_q <= ctrl.en;
      if (ctrl.en && !en_q) begin
        count <= reload_val;
      end else if (ctrl.en && tick) begin
        if (count != '0) begin
          count <= count - 1'b1;
        end else begin
          count <= ctrl.oneshot ? '0 : reload_val;
        end
      end

      // A terminal tick beats a simultaneous clear.
      if (!ctrl.en) begin
        raw_int <= 1'b0;
      end else if (terminal) begin
        raw_int <= 1'b1;
      end else if (eoi_clr) begin
        raw_int <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_timer_array.sv
// NUM_CH-channel APB down-counter timer; zero-wait-state slave, prdata registered in the setup phase.
// Optional shared prescaler enabled by APB_TIMER_PRESCALER_EN (0x10C unmapped otherwise).
module apb_timer_array
  import apb_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 12
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [NUM_CH-1:0] timer_int,
  output logic              timer_int_any
);

  ctrl_t             ctrl    [NUM_CH];
  logic [CNT_W-1:0]  load_r  [NUM_CH];
  logic [CNT_W-1:0]  count   [NUM_CH];
  logic [NUM_CH-1:0] raw_int;
  logic [NUM_CH-1:0] os_clr;
  logic [NUM_CH-1:0] eoi_clr;

  logic [ADDR_W-1:0] addr_al;
  logic [3:0]        ch_sel;
  logic [3:0]        reg_off;
  logic              ch_hit;
  logic              hit_intstat;
  logic              hit_eoi_all;
  logic              hit_raw;
  logic              hit_presc;
  logic              mapped;
  logic              wr_en;
  logic              tick;
  logic [31:0]       rd_val;
  logic              unused_bits;

  assign addr_al     = {paddr[ADDR_W-1:2], 2'b00};
  assign ch_sel      = paddr[7:4];
  assign reg_off     = {paddr[3:2], 2'b00};
  assign ch_hit      = (paddr[ADDR_W-1:8] == '0) && (int'(ch_sel) < NUM_CH);
  assign hit_intstat = (addr_al == ADDR_W'(INTSTAT_ADDR));
  assign hit_eoi_all = (addr_al == ADDR_W'(EOI_ALL_ADDR));
  assign hit_raw     = (addr_al == ADDR_W'(RAWINTSTAT_ADDR));
  assign mapped      = ch_hit || hit_intstat || hit_eoi_all || hit_raw || hit_presc;
  assign wr_en       = psel && penable && pwrite && mapped;
  assign unused_bits = ^{pwdata, paddr[1:0]};

`ifdef APB_TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] presc;
  logic [PRESCALE_W-1:0] div;

  assign hit_presc = (addr_al == ADDR_W'(PRESCALE_ADDR));
  assign tick      = (div == presc);

  // Writing PRESCALE restarts the divider so the new period starts cleanly.
  always_ff @(posedge pclk) begin
    if (preset) begin
      presc <= '0;
      div   <= '0;
    end else if (wr_en && hit_presc) begin
      presc <= pwdata[PRESCALE_W-1:0];
      div   <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
    end
  end
`else
  assign hit_presc = 1'b0;
  assign tick      = 1'b1;
`endif

  always_comb begin
    eoi_clr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eoi_clr[i] = wr_en && pwdata[0] &&
                   (hit_eoi_all || (ch_hit && ch_sel == 4'(i) && reg_off == 4'(EOI_OFF)));
    end
  end

  always_comb begin
    rd_val = '0;
    if (ch_hit) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_sel == 4'(i)) begin
          case (reg_off)
            4'(LOAD_OFF):  rd_val[CNT_W-1:0] = load_r[i];
            4'(VALUE_OFF): rd_val[CNT_W-1:0] = count[i];
            4'(CTRL_OFF):  rd_val[3:0]       = ctrl[i];
            default:       rd_val            = '0;
          endcase
        end
      end
    end
    if (hit_intstat) rd_val[NUM_CH-1:0] = timer_int;
    if (hit_raw)     rd_val[NUM_CH-1:0] = raw_int;
`ifdef APB_TIMER_PRESCALER_EN
    if (hit_presc)   rd_val[PRESCALE_W-1:0] = presc;
`endif
  end

  // A software CTRL write in the same cycle as a one-shot expiry overrides the HW EN clear.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        load_r[i] <= '0;
        ctrl[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en && ch_hit && ch_sel == 4'(i) && reg_off == 4'(LOAD_OFF)) begin
          load_r[i] <= pwdata[CNT_W-1:0];
        end
        if (wr_en && ch_hit && ch_sel == 4'(i) && reg_off == 4'(CTRL_OFF)) begin
          ctrl[i] <= ctrl_t'({pwdata[CTRL_ONESHOT_BIT], pwdata[CTRL_MASK_BIT],
                              pwdata[CTRL_MODE_BIT], pwdata[CTRL_EN_BIT]});
        end else if (os_clr[i]) begin
          ctrl[i].en <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      prdata  <= '0;
      pslverr <= 1'b0;
    end else begin
      if (psel && !penable && !pwrite) begin
        prdata <= rd_val;
      end
      if (psel && !penable) begin
        pslverr <= !mapped;
      end else if (!(psel && penable)) begin
        pslverr <= 1'b0;
      end
    end
  end

  assign pready        = 1'b1;
  assign timer_int_any = |timer_int;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    apb_timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .pclk        (pclk),
      .preset      (preset),
      .tick        (tick),
      .ctrl        (ctrl[g]),
      .load_val    (load_r[g]),
      .eoi_clr     (eoi_clr[g]),
      .count       (count[g]),
      .raw_int     (raw_int[g]),
      .timer_int   (timer_int[g]),
      .oneshot_clr (os_clr[g])
    );
  end

endmodule

// File: tb/tb_apb_timer_array.sv
// Scoreboard bench for apb_timer_array: random APB traffic against a cycle-level behavioural model.
module tb_apb_timer_array;
  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int AW  = 12;
  localparam logic [31:0] ONES = 32'((64'd1 << CW) - 1);
`ifdef APB_TIMER_PRESCALER_EN
  localparam bit HAS_PRESC = 1'b1;
`else
  localparam bit HAS_PRESC = 1'b0;
`endif

  logic          pclk, preset, psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata, prdata;
  logic          pready, pslverr, timer_int_any;
  logic [NCH-1:0] timer_int;

  apb_timer_array #(.NUM_CH(NCH), .CNT_W(CW), .ADDR_W(AW)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .timer_int(timer_int), .timer_int_any(timer_int_any)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_load [NCH];
  logic [31:0] m_cnt  [NCH];
  bit m_en [NCH], m_mode [NCH], m_mask [NCH], m_os [NCH], m_raw [NCH], m_prev_en [NCH];
  int m_presc, m_div;

  // kind: 0 unmapped, 1 channel register, 2 INTSTAT, 3 EOI_ALL, 4 RAWINTSTAT, 5 PRESCALE
  function automatic void dec(input logic [31:0] addr, output int kind, output int ch, output int off);
    int a;
    a = int'(addr) & ~3;
    ch = 0; off = 0; kind = 0;
    if (a < 'h100) begin
      ch = a / 16; off = a % 16;
      kind = (ch < NCH) ? 1 : 0;
    end else if (a == 'h100) kind = 2;
    else if (a == 'h104) kind = 3;
    else if (a == 'h108) kind = 4;
    else if (a == 'h10C && HAS_PRESC) kind = 5;
  endfunction

  function automatic void exp_read(input logic [31:0] addr, output logic [31:0] d, output logic err);
    int kind, ch, off;
    dec(addr, kind, ch, off);
    d = 0; err = (kind == 0);
    case (kind)
      1: case (off)
           0: d = m_load[ch];
           4: d = m_cnt[ch];
           8: d = {28'd0, m_os[ch], m_mask[ch], m_mode[ch], m_en[ch]};
           default: d = 0;
         endcase
      2: for (int i = 0; i < NCH; i++) d[i] = m_raw[i] && !m_mask[i];
      4: for (int i = 0; i < NCH; i++) d[i] = m_raw[i];
      5: d = m_presc;
      default: ;
    endcase
  endfunction

  task automatic model_step();
    int kind, ch, off;
    bit wr, tick, fired, os_stop, eoi;
    if (preset) begin
      for (int i = 0; i < NCH; i++) begin
        m_load[i] = 0; m_cnt[i] = ONES; m_en[i] = 0; m_mode[i] = 0; m_mask[i] = 0;
        m_os[i] = 0; m_raw[i] = 0; m_prev_en[i] = 0;
      end
      m_presc = 0; m_div = 0;
      return;
    end
    wr = psel && penable && pwrite;
    dec(32'(paddr), kind, ch, off);
    tick = HAS_PRESC ? (m_div == m_presc) : 1'b1;
    for (int i = 0; i < NCH; i++) begin
      fired = 0; os_stop = 0;
      if (m_en[i]) begin
        if (!m_prev_en[i]) m_cnt[i] = m_mode[i] ? m_load[i] : ONES;
        else if (tick) begin
          if (m_cnt[i] != 0) m_cnt[i] = m_cnt[i] - 1;
          else begin
            fired = 1; os_stop = m_os[i];
            m_cnt[i] = m_os[i] ? 0 : (m_mode[i] ? m_load[i] : ONES);
          end
        end
      end
      eoi = wr && pwdata[0] && (kind == 3 || (kind == 1 && ch == i && off == 12));
      if (!m_en[i]) m_raw[i] = 0;
      else if (fired) m_raw[i] = 1;
      else if (eoi) m_raw[i] = 0;
      m_prev_en[i] = m_en[i];
      if (wr && kind == 1 && ch == i && off == 8) begin
        m_en[i] = pwdata[0]; m_mode[i] = pwdata[1]; m_mask[i] = pwdata[2]; m_os[i] = pwdata[3];
      end else if (os_stop) m_en[i] = 0;
      if (wr && kind == 1 && ch == i && off == 0) m_load[i] = pwdata & ONES;
    end
    if (wr && kind == 5) begin
      m_presc = int'(pwdata[15:0]); m_div = 0;
    end else m_div = tick ? 0 : m_div + 1;
  endtask

  initial forever begin
    @(posedge pclk);
    model_step();
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          rd;
    logic [31:0] d;
    logic        err;
    string       nm;
  } exp_t;
  exp_t sbq[$];

  initial forever begin
    @(negedge pclk);
    if (chk_on) begin
      logic [31:0] ei;
      ei = 0;
      for (int i = 0; i < NCH; i++) ei[i] = m_raw[i] && !m_mask[i];
      chk("irq", {28'd0, timer_int_any, timer_int}, {28'd0, |ei[NCH-1:0], ei[NCH-1:0]});
      if (psel && penable) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (e.rd) chk(e.nm, prdata, e.d);
          chk({e.nm, "_err"}, {31'd0, pslverr}, {31'd0, e.err});
          chk({e.nm, "_rdy"}, {31'd0, pready}, 32'd1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apb(input bit rd, input logic [31:0] addr, input logic [31:0] data,
                     input bit use_c, input logic [31:0] cexp, input string nm);
    exp_t e;
    logic [31:0] d;
    logic er;
    exp_read(addr, d, er);
    e.rd = rd; e.d = use_c ? cexp : d; e.err = er; e.nm = nm;
    sbq.push_back(e);
    psel = 1; penable = 0; pwrite = !rd; paddr = AW'(addr); pwdata = data;
    @(posedge pclk); #1;
    penable = 1;
    @(posedge pclk); #1;
    psel = 0; penable = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm);
    apb(1'b0, a, d, 1'b0, 32'd0, nm);
  endtask
  task automatic rdm(input logic [31:0] a, input string nm);
    apb(1'b1, a, 32'd0, 1'b0, 32'd0, nm);
  endtask
  task automatic rdc(input logic [31:0] a, input logic [31:0] exp, input string nm);
    apb(1'b1, a, 32'd0, 1'b1, exp, nm);
  endtask

  task automatic wait_cnt0(input logic [31:0] v);
    int k;
    k = 0;
    while (!(m_cnt[0] == v && m_en[0] && m_prev_en[0]) && k < 100) begin
      idle(1); k++;
    end
    if (k >= 100) chk("wait_cnt0_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    preset = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    @(posedge pclk); #1;
    chk_on = 1;
    idle(2);
    preset = 0;

    rdc('h000, 0, "rst_load0"); rdc('h004, ONES, "rst_value0"); rdc('h008, 0, "rst_ctrl0");
    rdc('h108, 0, "rst_raw");   rdc('h100, 0, "rst_intstat"); rdc('h024, ONES, "rst_value2");

    wr('h000, 32'h12345, "w_trunc"); rdc('h000, 32'h2345, "load_trunc");

    wr('h030, 7, "w_unmap_ch"); rdc('h030, 0, "r_unmap_ch");
    wr('h1F0, 1, "w_unmap_hi"); rdc('h1F0, 0, "r_unmap_hi");
    rdc('h000, 32'h2345, "no_change"); rdm('h10C, "r_prescale");

    wr('h000, 5, "w_load0"); wr('h008, 3, "w_ctrl0");
    for (int i = 0; i < 10; i++) rdm('h004, "value0");

    wait_cnt0(1);
    wr('h00C, 1, "eoi_race"); rdc('h108, 1, "raw_after_race");
    wait_cnt0(4);
    wr('h00C, 1, "eoi_late"); rdm('h108, "raw_after_eoi");

    wr('h010, 3, "w_load1"); wr('h018, 32'hB, "w_ctrl1");
    idle(12);
    rdc('h018, 32'hA, "oneshot_ctrl"); rdc('h014, 0, "oneshot_value");

    wr('h020, 2, "w_load2"); wr('h028, 7, "w_ctrl2");
    idle(8);
    rdm('h108, "raw_masked"); rdm('h100, "intstat_masked");
    wr('h104, 1, "eoi_all"); rdm('h108, "raw_after_all");

`ifdef APB_TIMER_PRESCALER_EN
    wr('h10C, 3, "w_presc"); wr('h008, 0, "w_dis0"); wr('h000, 2, "w_load0p"); wr('h008, 3, "w_en0p");
    for (int i = 0; i < 15; i++) rdm('h004, "value_presc");
    rdc('h10C, 3, "r_presc");
    wr('h10C, 0, "w_presc0");
`endif

    wr('h000, 5, "w_load0r"); wr('h008, 3, "w_ctrl0r");
    idle(3);
    preset = 1; idle(1); preset = 0;
    rdc('h004, ONES, "midrst_value"); rdc('h008, 0, "midrst_ctrl");
    rdc('h108, 0, "midrst_raw");      rdc('h000, 0, "midrst_load");

    for (int n = 0; n < 500; n++) begin
      logic [31:0] a, d;
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) a = 32'($urandom_range(0, NCH) * 16 + $urandom_range(0, 3) * 4);
      else begin
        case ($urandom_range(0, 5))
          0: a = 'h100; 1: a = 'h104; 2: a = 'h108; 3: a = 'h10C; 4: a = 'h1F0; default: a = 'h200;
        endcase
      end
      a = a | 32'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      d = (r < 6) ? 32'($urandom_range(0, 9)) : (r < 8) ? 32'($urandom_range(0, 15)) : $urandom;
      if ((a & 'hFFC) == 'h10C) d = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) rdm(a, "rnd_rd");
      else wr(a, d, "rnd_wr");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      if ($urandom_range(0, 99) == 0) begin
        preset = 1; idle(1); preset = 0;
      end
    end

    idle(2);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
